// File: rtl/ps2_scancode_decoder_if.sv
// Bus between the PS/2 byte receiver, the scan-code decoder and the key consumer.
// Producer/consumer side uses master; the decoder uses slave.
interface ps2_scancode_decoder_if;
  logic       codeValid;
  logic [7:0] codeByte;
  logic       keyReady;
  logic       keyValid;
  logic [1:0] keyClass;
  logic [6:0] keyValue;
  logic [3:0] fifoCount;
  logic       overflow;

  modport master (
    output codeValid, codeByte, keyReady,
    input  keyValid, keyClass, keyValue, fifoCount, overflow
  );

  modport slave (
    input  codeValid, codeByte, keyReady,
    output keyValid, keyClass, keyValue, fifoCount, overflow
  );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// Decodes PS/2 set-2 scan codes into letter/number/enter key events,
// suppresses typematic repeats and buffers make events in a small FIFO.
module ps2_scancode_decoder #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                   clock27,
  input logic                   reset,
  ps2_scancode_decoder_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} state_t;

  state_t           state, state_next;
  logic             make_evt, break_evt;
  logic [1:0]       map_class;
  logic [6:0]       map_value;
  logic [7:0]       held_code;
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_next;
  logic [CNT_W-1:0] count, count_next;
  logic [1:0]       mem_class [FIFO_DEPTH];
  logic [6:0]       mem_value [FIFO_DEPTH];
  logic             key_valid, overflow_q;
  logic [1:0]       key_class;
  logic [6:0]       key_value;
  logic             push_req, push_ok, pop, full, ignore_byte;

  always_ff @(posedge clock27) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Prefix tracking; the byte itself is the event code, E0 only gates validity.
  always_comb begin
    state_next  = state;
    make_evt    = 1'b0;
    break_evt   = 1'b0;
    ignore_byte = (bus.codeByte == 8'hAA) || (bus.codeByte == 8'hFA) ||
                  (bus.codeByte == 8'hFE) || (bus.codeByte == 8'h00);
    if (bus.codeValid && !ignore_byte) begin
      if (bus.codeByte == 8'hE0) begin
        state_next = EXT;
      end else if (bus.codeByte == 8'hF0) begin
        case (state)
          IDLE:    state_next = BREAK;
          EXT:     state_next = EXT_BREAK;
          default: state_next = state;
        endcase
      end else begin
        case (state)
          IDLE:      make_evt  = 1'b1;
          BREAK:     break_evt = 1'b1;
          EXT:       make_evt  = (bus.codeByte == 8'h5A);
          EXT_BREAK: break_evt = (bus.codeByte == 8'h5A);
        endcase
        state_next = IDLE;
      end
    end
  end

  always_comb begin
    map_class = 2'd0;
    map_value = 7'd0;
    case (bus.codeByte)
      8'h1C: map_value = 7'd0;
      8'h32: map_value = 7'd1;
      8'h21: map_value = 7'd2;
      8'h23: map_value = 7'd3;
      8'h24: map_value = 7'd4;
      8'h2B: map_value = 7'd5;
      8'h34: map_value = 7'd6;
      8'h33: map_value = 7'd7;
      8'h43: map_value = 7'd8;
      8'h3B: map_value = 7'd9;
      8'h45: begin map_class = 2'd1; map_value = 7'd0; end
      8'h16: begin map_class = 2'd1; map_value = 7'd1; end
      8'h1E: begin map_class = 2'd1; map_value = 7'd2; end
      8'h26: begin map_class = 2'd1; map_value = 7'd3; end
      8'h25: begin map_class = 2'd1; map_value = 7'd4; end
      8'h2E: begin map_class = 2'd1; map_value = 7'd5; end
      8'h36: begin map_class = 2'd1; map_value = 7'd6; end
      8'h3D: begin map_class = 2'd1; map_value = 7'd7; end
      8'h3E: begin map_class = 2'd1; map_value = 7'd8; end
      8'h46: begin map_class = 2'd1; map_value = 7'd9; end
      8'h5A: begin map_class = 2'd2; map_value = 7'd55; end
      default: begin map_class = 2'd3; map_value = 7'd99; end
    endcase
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    push_req   = make_evt && (bus.codeByte != held_code);
    pop        = key_valid && bus.keyReady;
    full       = (count == CNT_W'(FIFO_DEPTH));
    push_ok    = push_req && (!full || pop);
    rd_next    = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    count_next = count;
    case ({push_ok, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clock27) begin
    if (push_ok) begin
      mem_class[wr_ptr] <= map_class;
      mem_value[wr_ptr] <= map_value;
    end
  end

  always_ff @(posedge clock27) begin
    if (reset) begin
      held_code  <= 8'h00;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      key_valid  <= 1'b0;
      key_class  <= 2'd0;
      key_value  <= 7'd0;
      overflow_q <= 1'b0;
    end else begin
      if (make_evt && (bus.codeByte != held_code)) held_code <= bus.codeByte;
      else if (break_evt && (bus.codeByte == held_code)) held_code <= 8'h00;
      if (push_req && !push_ok) overflow_q <= 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr    <= rd_next;
      count     <= count_next;
      key_valid <= (count_next != '0);
      // Head register follows the entry at the next read pointer, bypassing fresh writes.
      if (count_next != '0) begin
        if (push_ok && (wr_ptr == rd_next)) begin
          key_class <= map_class;
          key_value <= map_value;
        end else begin
          key_class <= mem_class[rd_next];
          key_value <= mem_value[rd_next];
        end
      end
    end
  end

  assign bus.keyValid  = key_valid;
  assign bus.keyClass  = key_class;
  assign bus.keyValue  = key_value;
  assign bus.fifoCount = count;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: inputs change and outputs are
// sampled on the falling clock edge.
module tb_ps2_scancode_decoder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  ps2_scancode_decoder_if bus ();

  ps2_scancode_decoder #(.FIFO_DEPTH(4)) dut (
    .clock27 (clk),
    .reset   (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.codeValid = 1'b1;
    bus.codeByte  = b;
    @(negedge clk);
    bus.codeValid = 1'b0;
    bus.codeByte  = 8'h00;
  endtask

  task automatic pop_check(input string tag, input int cls, input int val);
    check({tag, "_valid"}, 32'(bus.keyValid), 32'd1);
    check({tag, "_class"}, 32'(bus.keyClass), 32'(cls));
    check({tag, "_value"}, 32'(bus.keyValue), 32'(val));
    bus.keyReady = 1'b1;
    @(negedge clk);
    bus.keyReady = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, 32'(bus.keyValid), 32'd0);
    check({tag, "_class"}, 32'(bus.keyClass), 32'd0);
    check({tag, "_value"}, 32'(bus.keyValue), 32'd0);
    check({tag, "_count"}, 32'(bus.fifoCount), 32'd0);
    check({tag, "_ovf"},   32'(bus.overflow), 32'd0);
  endtask

  initial begin
    bus.codeValid = 1'b0;
    bus.codeByte  = 8'h00;
    bus.keyReady  = 1'b0;

    // Reset beats a simultaneous code strobe.
    @(negedge clk);
    rst = 1'b1;
    bus.codeValid = 1'b1;
    bus.codeByte  = 8'h1C;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.codeValid = 1'b0;
    bus.codeByte  = 8'h00;
    check_reset_state("reset");

    // Single letter, consumer ready: one-cycle latency then popped.
    bus.keyReady = 1'b1;
    send(8'h1C);
    check("lat_valid", 32'(bus.keyValid), 32'd1);
    check("lat_class", 32'(bus.keyClass), 32'd0);
    check("lat_value", 32'(bus.keyValue), 32'd0);
    @(negedge clk);
    check("lat_popped", 32'(bus.keyValid), 32'd0);
    @(negedge clk);
    check("empty_ready_count", 32'(bus.fifoCount), 32'd0);
    bus.keyReady = 1'b0;

    // Typematic suppression and re-press after break.
    send(8'h16); send(8'h16); send(8'h16);
    send(8'hF0); send(8'h16); send(8'h16);
    check("rep_count", 32'(bus.fifoCount), 32'd2);
    pop_check("rep0", 1, 1);
    pop_check("rep1", 1, 1);
    check("rep_empty", 32'(bus.keyValid), 32'd0);

    // Extended enter make/break, other extended code ignored.
    send(8'hE0); send(8'h5A);
    send(8'hE0); send(8'hF0); send(8'h5A);
    send(8'hE0); send(8'h75);
    check("ext_count", 32'(bus.fifoCount), 32'd1);
    pop_check("ext0", 2, 55);
    check("ext_empty", 32'(bus.fifoCount), 32'd0);

    // Fill past depth: fifth make dropped, overflow sticks.
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h24);
    check("full_count", 32'(bus.fifoCount), 32'd4);
    check("full_ovf",   32'(bus.overflow), 32'd1);
    check("full_head",  32'(bus.keyValue), 32'd0);
    // Push and pop together while full.
    bus.keyReady  = 1'b1;
    bus.codeValid = 1'b1;
    bus.codeByte  = 8'h43;
    @(negedge clk);
    bus.keyReady  = 1'b0;
    bus.codeValid = 1'b0;
    bus.codeByte  = 8'h00;
    check("pp_count", 32'(bus.fifoCount), 32'd4);
    check("pp_ovf",   32'(bus.overflow), 32'd1);
    pop_check("fifo1", 0, 1);
    pop_check("fifo2", 0, 2);
    pop_check("fifo3", 0, 3);
    pop_check("fifo4", 0, 8);
    check("fifo_empty", 32'(bus.fifoCount), 32'd0);
    check("fifo_ovf_sticky", 32'(bus.overflow), 32'd1);

    // Unknown code, ignored bytes, break of unknown, FSM back in IDLE.
    send(8'h5B);
    pop_check("unk", 3, 99);
    send(8'hAA); send(8'hFA); send(8'hF0); send(8'h5B);
    check("ign_count", 32'(bus.fifoCount), 32'd0);
    send(8'h1C);
    check("idle_count", 32'(bus.fifoCount), 32'd1);
    pop_check("idle", 0, 0);

    // Reset mid-prefix with a pending entry discards both.
    send(8'h32);
    send(8'hF0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("rst2");
    send(8'h1C);
    check("post_rst_count", 32'(bus.fifoCount), 32'd1);
    pop_check("post_rst", 0, 0);
    check("post_rst_empty", 32'(bus.keyValid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
